// File: rtl/alarm_event_gen.sv
// Alarm event source: start / ring-timeout / snooze-timeout pulses plus phase countdown.
// Optional snooze limit (alarm_off_o) compiled in with `define ALARM_SNOOZE_LIMIT_EN.
module alarm_event_gen #(
  parameter int ALARM_DURATION_SEC  = 60,
  parameter int SNOOZE_DURATION_SEC = 300,
  parameter int CNT_W               = 16
`ifdef ALARM_SNOOZE_LIMIT_EN
  , parameter int MAX_SNOOZE        = 3
`endif
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             sec_tick_i,
  input  logic [4:0]       cur_hour_i,
  input  logic [5:0]       cur_min_i,
  input  logic [5:0]       cur_sec_i,
  input  logic [4:0]       alarm_hour_i,
  input  logic [5:0]       alarm_min_i,
  input  logic             in_alarm_set_i,
  input  logic             in_alarm_i,
  input  logic             in_snooze_i,
`ifdef ALARM_SNOOZE_LIMIT_EN
  output logic             alarm_off_o,
`endif
  output logic             alarm_start_o,
  output logic             alarm_timeout_o,
  output logic             alarm_snooze_timeout_o,
  output logic [CNT_W-1:0] remaining_o
);

  typedef enum logic [1:0] {PH_IDLE, PH_ARMED, PH_RING, PH_SNOOZE} phase_t;

  localparam logic [CNT_W-1:0] RING_LOAD = CNT_W'(ALARM_DURATION_SEC);
  localparam logic [CNT_W-1:0] SNZ_LOAD  = CNT_W'(SNOOZE_DURATION_SEC);

  phase_t           phase, dec;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             done, done_nxt;     // current phase has already expired
  logic             fired, fired_nxt;   // start already issued this alarm minute
  logic             entry, minute_match, start_hit, expire, ring_exp, snz_exp;
  logic             to_hit;

  always_comb begin
    dec = PH_IDLE;
    if (in_alarm_i)          dec = PH_RING;
    else if (in_snooze_i)    dec = PH_SNOOZE;
    else if (in_alarm_set_i) dec = PH_ARMED;

    entry        = (dec != phase);
    minute_match = (cur_hour_i == alarm_hour_i) && (cur_min_i == alarm_min_i);
    start_hit    = (dec == PH_ARMED) && sec_tick_i && minute_match &&
                   (cur_sec_i == 6'd0) && !fired;
    fired_nxt    = minute_match ? (fired | start_hit) : 1'b0;

    cnt_nxt  = cnt;
    done_nxt = done;
    expire   = 1'b0;
    if (dec != PH_RING && dec != PH_SNOOZE) begin
      cnt_nxt  = '0;
      done_nxt = 1'b0;
    end else if (entry) begin
      // load wins over a coincident tick
      cnt_nxt  = (dec == PH_RING) ? RING_LOAD : SNZ_LOAD;
      done_nxt = 1'b0;
    end else if (sec_tick_i && !done) begin
      // a zero duration expires on the first tick, hence <= 1
      if (cnt <= CNT_W'(1)) begin
        expire   = 1'b1;
        done_nxt = 1'b1;
      end
      if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
    end
    ring_exp = expire && (dec == PH_RING);
    snz_exp  = expire && (dec == PH_SNOOZE);
  end

`ifdef ALARM_SNOOZE_LIMIT_EN
  logic [7:0] snz_cnt;
  logic       limit_hit;

  assign limit_hit = (snz_cnt == 8'(MAX_SNOOZE));
  assign to_hit    = ring_exp && !limit_hit;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      snz_cnt     <= '0;
      alarm_off_o <= 1'b0;
    end else begin
      alarm_off_o <= ring_exp && limit_hit;
      if (entry && (dec == PH_IDLE || dec == PH_ARMED))
        snz_cnt <= '0;
      else if (phase == PH_SNOOZE && dec == PH_RING && snz_cnt != 8'hFF)
        snz_cnt <= snz_cnt + 8'd1;
    end
  end
`else
  assign to_hit = ring_exp;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      phase                  <= PH_IDLE;
      cnt                    <= '0;
      done                   <= 1'b0;
      fired                  <= 1'b0;
      alarm_start_o          <= 1'b0;
      alarm_timeout_o        <= 1'b0;
      alarm_snooze_timeout_o <= 1'b0;
    end else begin
      phase                  <= dec;
      cnt                    <= cnt_nxt;
      done                   <= done_nxt;
      fired                  <= fired_nxt;
      alarm_start_o          <= start_hit;
      alarm_timeout_o        <= to_hit;
      alarm_snooze_timeout_o <= snz_exp;
    end
  end

  assign remaining_o = cnt;

endmodule

// File: tb/tb_alarm_event_gen.sv
// Directed bench for alarm_event_gen: per-cycle model compare plus literal checkpoints.
module tb_alarm_event_gen;
  localparam int AD = 3, SD = 5, CW = 16, MAXS = 2;

  logic clk = 0, rst_n = 1, sec_tick = 0;
  logic [4:0] cur_hour = 0, alarm_hour = 5'd7;
  logic [5:0] cur_min = 0, cur_sec = 0, alarm_min = 6'd30;
  logic in_set = 0, in_alarm = 0, in_snooze = 0;
  logic start, tmo, stmo, off;
  logic [CW-1:0] rem;
  int n_chk = 0, n_fail = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  alarm_event_gen #(.ALARM_DURATION_SEC(AD), .SNOOZE_DURATION_SEC(SD), .CNT_W(CW)
`ifdef ALARM_SNOOZE_LIMIT_EN
    , .MAX_SNOOZE(MAXS)
`endif
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .sec_tick_i(sec_tick),
    .cur_hour_i(cur_hour), .cur_min_i(cur_min), .cur_sec_i(cur_sec),
    .alarm_hour_i(alarm_hour), .alarm_min_i(alarm_min),
    .in_alarm_set_i(in_set), .in_alarm_i(in_alarm), .in_snooze_i(in_snooze),
`ifdef ALARM_SNOOZE_LIMIT_EN
    .alarm_off_o(off),
`endif
    .alarm_start_o(start), .alarm_timeout_o(tmo),
    .alarm_snooze_timeout_o(stmo), .remaining_o(rem)
  );
`ifndef ALARM_SNOOZE_LIMIT_EN
  assign off = 1'b0;
`endif

  // Model: phase is what the flags say; a phase entry restarts its timer,
  // the timer expires once on the tick that uses up its seconds.
  int m_ph, m_rem, m_snz;
  bit m_expired, m_fired, e_start, e_to, e_sto, e_off;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_rem = 0; m_snz = 0; m_expired = 0; m_fired = 0;
      e_start = 0; e_to = 0; e_sto = 0; e_off = 0;
    end else begin
      int d;
      bit same_min, ring_end;
      d = in_alarm ? 2 : in_snooze ? 3 : in_set ? 1 : 0;
      same_min = (cur_hour == alarm_hour) && (cur_min == alarm_min);
      e_start = (d == 1) && sec_tick && same_min && (cur_sec == 0) && !m_fired;
      m_fired = same_min && (m_fired || e_start);
      ring_end = 0; e_sto = 0;
      if (d < 2) begin
        m_rem = 0; m_expired = 0;
      end else if (d != m_ph) begin
        m_rem = (d == 2) ? AD : SD; m_expired = 0;
      end else if (sec_tick && !m_expired) begin
        if (m_rem <= 1) begin
          m_expired = 1;
          if (d == 2) ring_end = 1; else e_sto = 1;
        end
        if (m_rem > 0) m_rem = m_rem - 1;
      end
`ifdef ALARM_SNOOZE_LIMIT_EN
      e_off = ring_end && (m_snz == MAXS);
      e_to  = ring_end && (m_snz != MAXS);
      if (d != m_ph && d < 2) m_snz = 0;
      else if (m_ph == 3 && d == 2) m_snz = m_snz + 1;
`else
      e_off = 0;
      e_to  = ring_end;
`endif
      m_ph = d;
    end
  end

  always @(negedge clk) if (cmp_en) begin
    n_chk++;
    if (start !== e_start || tmo !== e_to || stmo !== e_sto || off !== e_off || rem !== CW'(m_rem)) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t got start=%b to=%b sto=%b off=%b rem=%0d want start=%b to=%b sto=%b off=%b rem=%0d",
               $time, start, tmo, stmo, off, rem, e_start, e_to, e_sto, e_off, m_rem);
    end
    n_chk++;
    if (int'(start) + int'(tmo) + int'(stmo) + int'(off) > 1) begin
      n_fail++;
      $display("FAIL mutex t=%0t got %b%b%b%b want at most one high", $time, start, tmo, stmo, off);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one-cycle tick with a new time value; returns 1 time unit after the sampling edge
  task automatic step(input int h, input int m, input int s);
    @(posedge clk); #1;
    cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s); sec_tick = 1;
    @(posedge clk); #1;
    sec_tick = 0;
  endtask

  initial begin
    #2 rst_n = 0;
    #1 cmp_en = 1;
    chk("reset_rem", int'(rem), 0);
    chk("reset_pulses", int'({start, tmo, stmo, off}), 0);
    cyc(2);
    rst_n = 1; in_set = 1;
    cyc(2);
    // alarm start at 07:30:00 only
    step(7, 29, 59); chk("no_start_0729_59", int'(start), 0);
    step(7, 30, 0);  chk("start_0730_00", int'(start), 1);
    step(7, 30, 1);  chk("no_start_0730_01", int'(start), 0);
    // ring countdown
    in_alarm = 1; cyc(1); chk("ring_load", int'(rem), 3);
    step(7, 30, 2); chk("ring_2", int'(rem), 2);
    step(7, 30, 3); chk("ring_1", int'(rem), 1);
    step(7, 30, 4); chk("ring_0", int'(rem), 0); chk("ring_timeout", int'(tmo), 1);
    step(7, 30, 5); chk("ring_no_second", int'(tmo), 0);
    // snooze countdown
    in_alarm = 0; in_snooze = 1; cyc(1); chk("snz_load", int'(rem), 5);
    for (int i = 6; i < 10; i++) step(7, 30, i);
    chk("snz_1", int'(rem), 1); chk("snz_not_yet", int'(stmo), 0);
    step(7, 30, 10); chk("snz_timeout", int'(stmo), 1); chk("snz_0", int'(rem), 0);
    // leave ring on the expiring tick
    in_snooze = 0; in_alarm = 1; cyc(1); chk("ring_reload", int'(rem), 3);
    step(7, 30, 11); step(7, 30, 12); chk("ring_pre_drop", int'(rem), 1);
    @(posedge clk); #1; in_alarm = 0; cur_sec = 6'd13; sec_tick = 1;
    @(posedge clk); #1; sec_tick = 0;
    chk("drop_no_timeout", int'(tmo), 0); chk("drop_rem", int'(rem), 0);
    // re-arm in the same minute, then new minute clears match-fired
    in_set = 0; cyc(1); in_set = 1; cyc(1);
    step(7, 30, 0); chk("rearm_no_start", int'(start), 0);
    step(7, 31, 0); chk("no_start_0731", int'(start), 0);
    step(7, 30, 0); chk("start_after_clear", int'(start), 1);
    // entry coincident with tick: load wins
    @(posedge clk); #1; in_alarm = 1; cur_sec = 6'd1; sec_tick = 1;
    @(posedge clk); #1; sec_tick = 0;
    chk("entry_tick_load", int'(rem), 3);
    // async reset mid-snooze
    in_alarm = 0; in_snooze = 1; cyc(1);
    step(7, 30, 2); step(7, 30, 3); chk("snz_mid", int'(rem), 3);
    @(posedge clk); #1; rst_n = 0; #1;
    chk("async_rst_rem", int'(rem), 0);
    chk("async_rst_pulses", int'({start, tmo, stmo, off}), 0);
    cyc(3); rst_n = 1; cyc(1);
    chk("post_rst_load", int'(rem), 5); chk("post_rst_no_pulse", int'({start, tmo, stmo, off}), 0);
    for (int i = 4; i < 10; i++) step(7, 30, i);
`ifdef ALARM_SNOOZE_LIMIT_EN
    // ring -> snooze -> ring -> snooze -> ring, expiry gives alarm_off_o
    in_snooze = 0; in_alarm = 0; cyc(1);
    in_alarm = 1; cyc(1); in_alarm = 0; in_snooze = 1; cyc(1);
    in_snooze = 0; in_alarm = 1; cyc(1); in_alarm = 0; in_snooze = 1; cyc(1);
    in_snooze = 0; in_alarm = 1; cyc(1);
    step(7, 30, 20); step(7, 30, 21); step(7, 30, 22);
    chk("limit_off", int'(off), 1); chk("limit_no_timeout", int'(tmo), 0);
    step(7, 30, 23); chk("limit_off_once", int'(off), 0);
`endif
    cyc(3);
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
